silife_sync_sequencer: RTL

- Upstream controller for silife_grid_sync: sequences one generation step of the local grid.
- Drives the sync clock and sync-active strobe during the edge-cell exchange with neighbouring chips.
- Waits for the exchange to drain, then issues a one-cycle update pulse to the cell array.
- Also supports a local-only step (no neighbour exchange), busy-drain timeout detection and a generation counter.

---
 rtl/silife_sync_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/silife_sync_sequencer.sv
// Generation-step sequencer for silife_grid_sync: runs the edge-exchange sync clock,
// waits for the exchange to drain, then pulses a one-cycle grid update.
module silife_sync_sequencer #(
    parameter int CLK_DIV  = 4,
    parameter int PULSES   = 34,
    parameter int TIMEOUT  = 255,
    parameter int GEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_step,
    input  logic                i_sync_enable,
    input  logic                i_busy,
    output logic                o_sync_clk_syn,
    output logic                o_sync_active_syn,
    output logic                o_grid_update,
    output logic                o_ready,
    output logic                o_timeout,
    output logic [GEN_BITS-1:0] o_gen_count
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int PUL_W = $clog2(PULSES + 1);
    localparam int DRN_W = $clog2(TIMEOUT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(PULSES);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CLOCK,
        S_DRAIN,
        S_UPDATE
    } state_t;

    state_t              r_state, w_state;
    logic [DIV_W-1:0]    r_div, w_div;
    logic [PUL_W-1:0]    r_pulse, w_pulse;
    logic                r_phase, w_phase;
    logic [DRN_W-1:0]    r_drain, w_drain;
    logic                r_timeout, w_timeout;
    logic                r_sync_clk, r_sync_active, r_grid_update;
    logic                w_sync_clk, w_sync_active;
    logic [GEN_BITS-1:0] r_gen_count;

    always_comb begin
        w_state   = r_state;
        w_div     = r_div;
        w_pulse   = r_pulse;
        w_phase   = r_phase;
        w_drain   = r_drain;
        w_timeout = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (i_step) begin
                    w_timeout = 1'b0;
                    w_div     = '0;
                    w_state   = i_sync_enable ? S_ARM : S_UPDATE;
                end
            end
            S_ARM: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_phase = 1'b0;
                    w_pulse = '0;
                    w_state = S_CLOCK;
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            S_CLOCK: begin
                // r_phase: 0 = low half, 1 = high half of the current sync pulse
                if (r_div == DIV_LAST) begin
                    w_div = '0;
                    if (!r_phase) begin
                        w_phase = 1'b1;
                        w_pulse = r_pulse + PUL_W'(1);
                    end else if (r_pulse == PUL_LAST) begin
                        w_phase = 1'b0;
                        w_drain = '0;
                        w_state = S_DRAIN;
                    end else begin
                        w_phase = 1'b0;
                    end
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            S_DRAIN: begin
                if (!i_busy) begin
                    w_state = S_UPDATE;
                end else if (r_drain == DRN_LAST) begin
                    w_timeout = 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    w_drain = r_drain + DRN_W'(1);
                end
            end
            S_UPDATE: w_state = S_IDLE;
            default:  w_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state change.
    always_comb begin
        w_sync_active = (w_state == S_ARM) || (w_state == S_CLOCK);
        w_sync_clk    = (w_state == S_CLOCK) && w_phase;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_div         <= '0;
            r_pulse       <= '0;
            r_phase       <= 1'b0;
            r_drain       <= '0;
            r_timeout     <= 1'b0;
            r_sync_clk    <= 1'b0;
            r_sync_active <= 1'b0;
            r_grid_update <= 1'b0;
            r_gen_count   <= '0;
        end else begin
            r_state       <= w_state;
            r_div         <= w_div;
            r_pulse       <= w_pulse;
            r_phase       <= w_phase;
            r_drain       <= w_drain;
            r_timeout     <= w_timeout;
            r_sync_clk    <= w_sync_clk;
            r_sync_active <= w_sync_active;
            r_grid_update <= (w_state == S_UPDATE);
            if (w_state == S_UPDATE) begin
                r_gen_count <= r_gen_count + GEN_BITS'(1);
            end
        end
    end

    assign o_sync_clk_syn    = r_sync_clk;
    assign o_sync_active_syn = r_sync_active;
    assign o_grid_update     = r_grid_update;
    assign o_ready           = (r_state == S_IDLE);
    assign o_timeout         = r_timeout;
    assign o_gen_count       = r_gen_count;

endmodule
